// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared constants, target type and helpers for the dispatch queue
package dispatch_queue_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // default widths (word, inner instruction, ROB tag, register index)
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_WORD_W = 32;
   localparam int DEF_INST_W = 6;
   localparam int DEF_TAG_W  = 4;
   localparam int DEF_REG_W  = 5;

   localparam int LSB_W   = 2;
   localparam int GOAL_W  = 3;
   localparam int STALL_W = 32;

   // dec_lsb_in bit positions
   localparam int LSB_SEL_BIT   = 1;
   localparam int LSB_STORE_BIT = 0;

   typedef enum logic {
      TGT_RS  = 1'b0,
      TGT_LSB = 1'b1
   } target_e;

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + STALL_W'(1);
   endfunction

endpackage

// File: rtl/dispatch_queue_fifo.sv
// rtl/dispatch_queue_fifo.sv - in-order storage array with wrapping pointers, count and flush
module dq_fifo
   import dispatch_queue_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ENTRY_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_enq,
   input  logic               i_deq,
   input  logic               i_flush,
   input  logic [ENTRY_W-1:0] i_wdata,
   output logic [ENTRY_W-1:0] o_rdata,
   output logic               o_full,
   output logic               o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;

   // payload storage; no reset needed because reads are gated by count
   always_ff @(posedge clk) begin
      if (i_enq) r_mem[r_tail] <= i_wdata;
   end

   // pointers wrap naturally at DEPTH (power of two); flush empties the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_enq) r_tail <= r_tail + PTR_W'(1);
         if (i_deq) r_head <= r_head + PTR_W'(1);
         r_count <= r_count + CNT_W'(i_enq) - CNT_W'(i_deq);
      end
   end

   assign o_rdata = r_mem[r_head];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - decoder-to-RS/LSB dispatch FIFO with ROB tag handshake and stall counter
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int WORD_W = DEF_WORD_W,
   parameter int INST_W = DEF_INST_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_in,
   input  logic               dec_valid_in,
   output logic               dec_ready_out,
   input  logic [INST_W-1:0]  dec_inst_in,
   input  logic [WORD_W-1:0]  dec_imm_in,
   input  logic [WORD_W-1:0]  dec_pc_in,
   input  logic [REG_W-1:0]   dec_rs1_in,
   input  logic [REG_W-1:0]   dec_rs2_in,
   input  logic [REG_W-1:0]   dec_rd_in,
   input  logic [LSB_W-1:0]   dec_lsb_in,
   input  logic [GOAL_W-1:0]  dec_goal_in,
   input  logic               rob_ready_in,
   input  logic [TAG_W-1:0]   rob_tag_in,
   output logic               rob_alloc_out,
   output logic [INST_W-1:0]  inst_out,
   output logic [WORD_W-1:0]  imm_out,
   output logic [WORD_W-1:0]  pc_out,
   output logic [REG_W-1:0]   rs1_out,
   output logic [REG_W-1:0]   rs2_out,
   output logic [REG_W-1:0]   rd_out,
   output logic [TAG_W-1:0]   dest_out,
   input  logic               rs_ready_in,
   output logic               rs_valid_out,
   input  logic               lsb_ready_in,
   output logic               lsb_valid_out,
   output logic               lsb_store_out,
   output logic [GOAL_W-1:0]  lsb_goal_out,
   output logic [STALL_W-1:0] stall_cnt_out
);

   localparam int ENTRY_W = INST_W + 2 * WORD_W + 3 * REG_W + LSB_W + GOAL_W;

   logic [ENTRY_W-1:0] w_wdata;
   logic [ENTRY_W-1:0] w_rdata;
   logic [ENTRY_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_enq;
   logic               w_fire;
   logic               w_tgt_ready;
   target_e            w_tgt;
   logic [LSB_W-1:0]   w_h_lsb;
   logic [STALL_W-1:0] r_stall;

   assign w_wdata = {dec_inst_in, dec_imm_in, dec_pc_in, dec_rs1_in, dec_rs2_in,
                     dec_rd_in, dec_lsb_in, dec_goal_in};

   dq_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_enq   (w_enq),
      .i_deq   (w_fire),
      .i_flush (flush_in),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // head fields read as zero when empty so outputs are clean out of reset
   assign w_head = w_empty ? '0 : w_rdata;
   assign {inst_out, imm_out, pc_out, rs1_out, rs2_out, rd_out, w_h_lsb, lsb_goal_out} = w_head;

   // no full bypass: a full queue refuses even if the head leaves this cycle
   assign dec_ready_out = ~w_full;
   assign w_enq         = dec_valid_in & ~w_full & ~flush_in;

   assign w_tgt       = target_e'(w_h_lsb[LSB_SEL_BIT]);
   assign w_tgt_ready = (w_tgt == TGT_LSB) ? lsb_ready_in : rs_ready_in;
   assign w_fire      = ~w_empty & rob_ready_in & w_tgt_ready & ~flush_in;

   assign rob_alloc_out = w_fire;
   assign rs_valid_out  = w_fire & (w_tgt == TGT_RS);
   assign lsb_valid_out = w_fire & (w_tgt == TGT_LSB);
   assign lsb_store_out = w_h_lsb[LSB_STORE_BIT];
   assign dest_out      = w_fire ? rob_tag_in : '0;

   // count cycles where an instruction waits at the head; flush cycles are not stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
      end else if (~w_empty & ~w_fire & ~flush_in) begin
         r_stall <= sat_inc(r_stall);
      end
   end

   assign stall_cnt_out = r_stall;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - randomized and directed checks of dispatch_queue against a queue model
module tb_dispatch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_in;
   logic        dec_valid_in;
   logic        dec_ready_out;
   logic [5:0]  dec_inst_in;
   logic [31:0] dec_imm_in;
   logic [31:0] dec_pc_in;
   logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in;
   logic [1:0]  dec_lsb_in;
   logic [2:0]  dec_goal_in;
   logic        rob_ready_in;
   logic [3:0]  rob_tag_in;
   logic        rob_alloc_out;
   logic [5:0]  inst_out;
   logic [31:0] imm_out, pc_out;
   logic [4:0]  rs1_out, rs2_out, rd_out;
   logic [3:0]  dest_out;
   logic        rs_ready_in, rs_valid_out;
   logic        lsb_ready_in, lsb_valid_out;
   logic        lsb_store_out;
   logic [2:0]  lsb_goal_out;
   logic [31:0] stall_cnt_out;

   dispatch_queue dut (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
      .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
      .dec_inst_in(dec_inst_in), .dec_imm_in(dec_imm_in), .dec_pc_in(dec_pc_in),
      .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
      .dec_lsb_in(dec_lsb_in), .dec_goal_in(dec_goal_in),
      .rob_ready_in(rob_ready_in), .rob_tag_in(rob_tag_in), .rob_alloc_out(rob_alloc_out),
      .inst_out(inst_out), .imm_out(imm_out), .pc_out(pc_out),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .dest_out(dest_out),
      .rs_ready_in(rs_ready_in), .rs_valid_out(rs_valid_out),
      .lsb_ready_in(lsb_ready_in), .lsb_valid_out(lsb_valid_out),
      .lsb_store_out(lsb_store_out), .lsb_goal_out(lsb_goal_out),
      .stall_cnt_out(stall_cnt_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  inst;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [1:0]  lsb;
      logic [2:0]  goal;
   } ent_t;

   localparam int DEPTH = 4;

   ent_t        mq[$];
   logic [31:0] m_stall;
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_dec(input logic v, input logic [31:0] pc, input logic [1:0] lsb);
      dec_valid_in = v;
      dec_pc_in    = pc;
      dec_lsb_in   = lsb;
      dec_inst_in  = 6'($urandom);
      dec_imm_in   = $urandom;
      dec_rs1_in   = 5'($urandom);
      dec_rs2_in   = 5'($urandom);
      dec_rd_in    = 5'($urandom);
      dec_goal_in  = 3'($urandom);
      rob_tag_in   = 4'($urandom);
   endtask

   task automatic set_rdy(input logic rob, input logic rs, input logic lsb, input logic fl);
      rob_ready_in = rob;
      rs_ready_in  = rs;
      lsb_ready_in = lsb;
      flush_in     = fl;
   endtask

   // one clock: predict from model + current inputs, compare at negedge, advance model at posedge
   task automatic step();
      bit   fire, enq, to_lsb;
      ent_t h, n;
      @(negedge clk);
      enq    = dec_valid_in && (mq.size() < DEPTH) && !flush_in;
      fire   = 0;
      to_lsb = 0;
      if (mq.size() != 0) begin
         h      = mq[0];
         to_lsb = h.lsb[1];
         fire   = rob_ready_in && (to_lsb ? lsb_ready_in : rs_ready_in) && !flush_in;
      end
      check("dec_ready", 128'(dec_ready_out), 128'(mq.size() < DEPTH));
      check("rob_alloc", 128'(rob_alloc_out), 128'(fire));
      check("rs_valid", 128'(rs_valid_out), 128'(fire && !to_lsb));
      check("lsb_valid", 128'(lsb_valid_out), 128'(fire && to_lsb));
      check("stall_cnt", 128'(stall_cnt_out), 128'(m_stall));
      if (mq.size() != 0)
         check("head", 128'({inst_out, imm_out, pc_out, rs1_out, rs2_out, rd_out, lsb_store_out, lsb_goal_out}),
               128'({h.inst, h.imm, h.pc, h.rs1, h.rs2, h.rd, h.lsb[0], h.goal}));
      if (fire) check("dest", 128'(dest_out), 128'(rob_tag_in));
      n = '{dec_inst_in, dec_imm_in, dec_pc_in, dec_rs1_in, dec_rs2_in, dec_rd_in, dec_lsb_in, dec_goal_in};
      @(posedge clk);
      if (flush_in) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && !fire && m_stall != 32'hffff_ffff) m_stall++;
         if (fire) void'(mq.pop_front());
         if (enq) mq.push_back(n);
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_rdy(0, 0, 0, 0);
      set_dec(0, 0, 2'b00);
      m_stall = 0;
      #12;
      check("rst_alloc", 128'(rob_alloc_out), 128'(0));
      check("rst_pc", 128'(pc_out), 128'(0));
      check("rst_stall", 128'(stall_cnt_out), 128'(0));
      check("rst_ready", 128'(dec_ready_out), 128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fill: 5 pushes with RS/ROB blocked, then drain in order
      for (int i = 0; i < 5; i++) begin
         set_dec(1, 32'(i * 4), 2'b00);
         step();
      end
      check("fill_size", 128'(mq.size()), 128'(4));
      set_dec(0, 0, 2'b00);
      set_rdy(1, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", 128'(pc_out), 128'(i * 4));
         step();
      end

      // routing: ADD, LW, SW with everything ready
      set_dec(1, 32'h100, 2'b00); step();
      set_dec(1, 32'h104, 2'b10); step();
      set_dec(1, 32'h108, 2'b11); step();
      set_dec(0, 0, 2'b00); step(); step();

      // head block: LSB op at head with LSB busy, RS op behind it
      set_rdy(1, 1, 0, 0);
      set_dec(1, 32'h200, 2'b10); step();
      set_dec(1, 32'h204, 2'b00); step();
      set_dec(0, 0, 2'b00);
      begin
         logic [31:0] s0;
         s0 = stall_cnt_out;
         step(); step(); step();
         check("block_stall", 128'(stall_cnt_out - s0), 128'(3));
      end
      set_rdy(1, 1, 1, 0); step(); step(); step();

      // ROB full with two entries, then released
      set_rdy(0, 1, 1, 0);
      set_dec(1, 32'h300, 2'b00); step();
      set_dec(1, 32'h304, 2'b10); step();
      set_dec(0, 0, 2'b00); step();
      set_rdy(1, 1, 1, 0); step(); step(); step();

      // flush with three entries while decoder and targets are ready
      set_rdy(0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         set_dec(1, 32'h400 + 32'(i * 4), 2'b00);
         step();
      end
      set_rdy(1, 1, 1, 1);
      set_dec(1, 32'h500, 2'b00);
      step();
      set_rdy(1, 1, 1, 0);
      set_dec(0, 0, 2'b00);
      check("flush_ready", 128'(dec_ready_out), 128'(1));
      check("flush_empty", 128'(rob_alloc_out), 128'(0));
      step();

      // asynchronous reset with three entries queued
      set_rdy(0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         set_dec(1, 32'h600 + 32'(i * 4), 2'b00);
         step();
      end
      set_dec(0, 0, 2'b00);
      set_rdy(1, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_alloc", 128'(rob_alloc_out), 128'(0));
      check("arst_rs", 128'(rs_valid_out), 128'(0));
      check("arst_ready", 128'(dec_ready_out), 128'(1));
      check("arst_stall", 128'(stall_cnt_out), 128'(0));
      mq.delete();
      m_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_dec(1, 32'h700, 2'b10); step();
      set_dec(0, 0, 2'b00); step(); step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         set_dec(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom));
         set_rdy(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
